// File: rtl/id_pipe_stage_if.sv
// ---------------------------------------------------------------------------
// id_pipe_stage_if
//
// Bundles every handshake and data signal of the registered ID stage so the
// stage, its IF-side producer and its EX-side consumer share one definition.
//
// Parameters
//   DATA_W : operand/data width
//   PC_W   : program-counter width
//   EXE_W  : width of the pass-through EXE command
//   CNT_W  : width of the hazard-stall counter
//
// Signal groups
//   IF -> ID   : in_valid, instr, pc_in, rdata1, rdata2, c_* control bits
//   ID -> IF   : in_ready, src2_addr, br_taken, br_target
//   ID -> EX   : out_valid, out_val1/2, out_st_val, out_src1, out_src2_fw,
//                out_dest, out_exe, out_wb_en, out_mem_r, out_mem_w
//   EX -> ID   : out_ready
//   status     : stall_cycles
//
// Modports
//   master : the environment around the stage (IF, controller, RF, EX)
//   slave  : the ID stage itself
// ---------------------------------------------------------------------------
interface id_pipe_stage_if #(
    parameter int DATA_W = 32,
    parameter int PC_W   = 32,
    parameter int EXE_W  = 4,
    parameter int CNT_W  = 16
);
    // Upstream handshake and instruction payload
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       instr;
    logic [PC_W-1:0]   pc_in;
    logic [DATA_W-1:0] rdata1;
    logic [DATA_W-1:0] rdata2;

    // Controller decode bits
    logic              c_is_imm;
    logic              c_st_or_bne;
    logic              c_wb_en;
    logic              c_mem_r;
    logic              c_mem_w;
    logic [1:0]        c_br;
    logic [EXE_W-1:0]  c_exe;

    // Combinational answers back to IF / register file
    logic [4:0]        src2_addr;
    logic              br_taken;
    logic [PC_W-1:0]   br_target;

    // ID/EX register contents and downstream handshake
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_val1;
    logic [DATA_W-1:0] out_val2;
    logic [DATA_W-1:0] out_st_val;
    logic [4:0]        out_src1;
    logic [4:0]        out_src2_fw;
    logic [4:0]        out_dest;
    logic [EXE_W-1:0]  out_exe;
    logic              out_wb_en;
    logic              out_mem_r;
    logic              out_mem_w;

    // Status
    logic [CNT_W-1:0]  stall_cycles;

    modport master (
        output in_valid, instr, pc_in, rdata1, rdata2,
               c_is_imm, c_st_or_bne, c_wb_en, c_mem_r, c_mem_w, c_br, c_exe,
               out_ready,
        input  in_ready, src2_addr, br_taken, br_target,
               out_valid, out_val1, out_val2, out_st_val,
               out_src1, out_src2_fw, out_dest, out_exe,
               out_wb_en, out_mem_r, out_mem_w,
               stall_cycles
    );

    modport slave (
        input  in_valid, instr, pc_in, rdata1, rdata2,
               c_is_imm, c_st_or_bne, c_wb_en, c_mem_r, c_mem_w, c_br, c_exe,
               out_ready,
        output in_ready, src2_addr, br_taken, br_target,
               out_valid, out_val1, out_val2, out_st_val,
               out_src1, out_src2_fw, out_dest, out_exe,
               out_wb_en, out_mem_r, out_mem_w,
               stall_cycles
    );
endinterface

// File: rtl/id_pipe_stage.sv
// ---------------------------------------------------------------------------
// id_pipe_stage
//
// Registered instruction-decode stage between IF and EX. It builds the EX
// operands from the register-file data and controller bits, resolves
// branches in ID, tracks the destinations of the last HIST_DEPTH issue slots
// to detect RAW hazards, inserts bubbles when a hazard is present and holds
// the result in an ID/EX register guarded by a valid/ready handshake.
//
// Parameters
//   DATA_W     : operand/data width (>= 16)
//   PC_W       : program-counter width (>= 16)
//   EXE_W      : width of the pass-through EXE command
//   HIST_DEPTH : number of issued destinations tracked for hazards (>= 1)
//   CNT_W      : width of the saturating stall-cycle counter
//
// Ports
//   clk : clock, all state on the rising edge
//   rst : asynchronous active-high reset
//   bus : id_pipe_stage_if.slave carrying the IF-side handshake and payload,
//         the controller bits, the combinational branch/src2 answers, the
//         ID/EX register outputs with their handshake and stall_cycles
//
// Configuration macro
//   IDPIPE_FWD_EN : when defined, EX is assumed to forward ALU results, so
//                   only a load in ID/EX feeding the next instruction stalls.
//                   When undefined, any match in the history stalls.
//                   Branch operands are never forwarded in either build.
// ---------------------------------------------------------------------------
module id_pipe_stage #(
    parameter int DATA_W     = 32,
    parameter int PC_W       = 32,
    parameter int EXE_W      = 4,
    parameter int HIST_DEPTH = 3,
    parameter int CNT_W      = 16
) (
    input logic            clk,
    input logic            rst,
    id_pipe_stage_if.slave bus
);

    typedef enum logic [1:0] {
        BR_NONE = 2'd0,
        BR_EQ   = 2'd1,
        BR_NE   = 2'd2,
        BR_JMP  = 2'd3
    } br_kind_e;

    // Everything the ID/EX register carries besides its valid bit
    typedef struct packed {
        logic [DATA_W-1:0] val1;
        logic [DATA_W-1:0] val2;
        logic [DATA_W-1:0] stVal;
        logic [4:0]        src1;
        logic [4:0]        src2Fw;
        logic [4:0]        dest;
        logic [EXE_W-1:0]  exe;
        logic              wbEn;
        logic              memR;
        logic              memW;
    } idex_t;

    // ------------------------------------------------------------------
    // Instruction field decode
    // ------------------------------------------------------------------
    logic [4:0]        rsAddr;
    logic [4:0]        rtAddr;
    logic [4:0]        rdAddr;
    logic [15:0]       imm;
    logic [4:0]        src2Addr;
    logic [4:0]        destAddr;
    logic              destWrites;
    logic              useSrc2;
    logic [DATA_W-1:0] immData;
    logic [PC_W-1:0]   immPc;
    br_kind_e          brKind;
    logic              isCondBr;
    logic              unusedOpcode;

    assign rsAddr   = bus.instr[25:21];
    assign rtAddr   = bus.instr[20:16];
    assign rdAddr   = bus.instr[15:11];
    assign imm      = bus.instr[15:0];

    // The opcode field is decoded by the controller, not here
    assign unusedOpcode = ^bus.instr[31:26];

    // Stores and BNE read their second operand from the rd field
    assign src2Addr = bus.c_st_or_bne ? rdAddr : rtAddr;
    assign destAddr = bus.c_is_imm ? rtAddr : rdAddr;

    // Writes to r0 are architecturally discarded, so they never create hazards
    assign destWrites = bus.c_wb_en && (destAddr != 5'd0);

    // The second source is live for register-register ops and for stores/BNE
    assign useSrc2  = !bus.c_is_imm || bus.c_st_or_bne;

    assign immData  = DATA_W'($signed(imm));
    assign immPc    = PC_W'($signed(imm));

    assign brKind   = br_kind_e'(bus.c_br);
    assign isCondBr = (brKind == BR_EQ) || (brKind == BR_NE);

    assign bus.src2_addr = src2Addr;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic                        outValid_q, outValid_d;
    idex_t                       idex_q, idex_d;
    logic [HIST_DEPTH-1:0]       histValid_q, histValid_d;
    logic [HIST_DEPTH-1:0][4:0]  histDest_q, histDest_d;
    logic [HIST_DEPTH-1:0]       histLoad_q, histLoad_d;
    logic [CNT_W-1:0]            stall_q, stall_d;
    logic                        unusedHistLoad;

    // Only entry 0's load flag matters in the forwarding build, and none of
    // them in the non-forwarding build; the rest are kept for debug visibility.
    assign unusedHistLoad = ^histLoad_q;

    // ------------------------------------------------------------------
    // Hazard detection against the in-flight history
    // ------------------------------------------------------------------
    logic [HIST_DEPTH-1:0] histMatch;
    logic                  matchAny;
    logic                  loadUse;
    logic                  dataHazard;
    logic                  hazard;

    // Each entry only becomes valid for a real (non-r0) write, so a valid
    // entry whose destination equals a live source is a RAW dependency.
    always_comb begin
        histMatch = '0;
        for (int i = 0; i < HIST_DEPTH; i++) begin
            histMatch[i] = histValid_q[i] &&
                           (((rsAddr != 5'd0) && (histDest_q[i] == rsAddr)) ||
                            (useSrc2 && (src2Addr != 5'd0) &&
                             (histDest_q[i] == src2Addr)));
        end
    end

    assign matchAny = |histMatch;
    assign loadUse  = histMatch[0] && histLoad_q[0];

`ifdef IDPIPE_FWD_EN
    assign dataHazard = loadUse;
`else
    assign dataHazard = matchAny;
`endif

    // Branches compare in ID, so their operands must already be in the RF
    assign hazard = bus.in_valid && (isCondBr ? matchAny : dataHazard);

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic adv;
    logic accept;
    logic stallEvent;

    // The ID/EX slot can take something new when it is empty or being drained
    assign adv        = !outValid_q || bus.out_ready;
    assign bus.in_ready = adv && !hazard;
    assign accept     = bus.in_valid && adv && !hazard;
    assign stallEvent = adv && hazard;

    // ------------------------------------------------------------------
    // Branch resolution
    // ------------------------------------------------------------------
    logic brCond;

    always_comb begin
        brCond = 1'b0;
        unique case (brKind)
            BR_EQ:   brCond = (bus.rdata1 == bus.rdata2);
            BR_NE:   brCond = (bus.rdata1 != bus.rdata2);
            BR_JMP:  brCond = 1'b1;
            default: brCond = 1'b0;
        endcase
    end

    assign bus.br_taken  = accept && brCond;
    assign bus.br_target = bus.pc_in + PC_W'(1) + immPc;

    // ------------------------------------------------------------------
    // Next-state for the ID/EX register
    // ------------------------------------------------------------------
    idex_t newIdex;

    always_comb begin
        newIdex        = '0;
        newIdex.val1   = bus.rdata1;
        newIdex.val2   = bus.c_is_imm ? immData : bus.rdata2;
        newIdex.stVal  = bus.rdata2;
        newIdex.src1   = rsAddr;
        newIdex.src2Fw = bus.c_is_imm ? 5'd0 : rtAddr;
        newIdex.dest   = destAddr;
        newIdex.exe    = bus.c_exe;
        newIdex.wbEn   = bus.c_wb_en;
        newIdex.memR   = bus.c_mem_r;
        newIdex.memW   = bus.c_mem_w;
    end

    // A bubble only clears the valid bit; the payload is held so it does not
    // toggle needlessly while EX ignores it.
    always_comb begin
        outValid_d = outValid_q;
        idex_d     = idex_q;
        if (adv) begin
            outValid_d = accept;
            if (accept) begin
                idex_d = newIdex;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state for the hazard history
    // ------------------------------------------------------------------
    // Entry 0 tracks the ID/EX register, so the history moves exactly when
    // ID/EX does; a bubble shifts in an invalid entry.
    always_comb begin
        histValid_d = histValid_q;
        histDest_d  = histDest_q;
        histLoad_d  = histLoad_q;
        if (adv) begin
            for (int i = HIST_DEPTH - 1; i >= 1; i--) begin
                histValid_d[i] = histValid_q[i-1];
                histDest_d[i]  = histDest_q[i-1];
                histLoad_d[i]  = histLoad_q[i-1];
            end
            histValid_d[0] = accept && destWrites;
            histDest_d[0]  = accept ? destAddr : 5'd0;
            histLoad_d[0]  = accept && bus.c_mem_r;
        end
    end

    // ------------------------------------------------------------------
    // Next-state for the stall counter
    // ------------------------------------------------------------------
    // Only cycles where a bubble is actually inserted are counted; cycles
    // frozen by back-pressure are not hazard stalls.
    always_comb begin
        stall_d = stall_q;
        if (stallEvent && (stall_q != {CNT_W{1'b1}})) begin
            stall_d = stall_q + CNT_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outValid_q  <= 1'b0;
            idex_q      <= '0;
            histValid_q <= '0;
            histDest_q  <= '0;
            histLoad_q  <= '0;
            stall_q     <= '0;
        end else begin
            outValid_q  <= outValid_d;
            idex_q      <= idex_d;
            histValid_q <= histValid_d;
            histDest_q  <= histDest_d;
            histLoad_q  <= histLoad_d;
            stall_q     <= stall_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.out_valid    = outValid_q;
    assign bus.out_val1     = idex_q.val1;
    assign bus.out_val2     = idex_q.val2;
    assign bus.out_st_val   = idex_q.stVal;
    assign bus.out_src1     = idex_q.src1;
    assign bus.out_src2_fw  = idex_q.src2Fw;
    assign bus.out_dest     = idex_q.dest;
    assign bus.out_exe      = idex_q.exe;
    assign bus.out_wb_en    = idex_q.wbEn;
    assign bus.out_mem_r    = idex_q.memR;
    assign bus.out_mem_w    = idex_q.memW;
    assign bus.stall_cycles = stall_q;

endmodule

// File: doc/id_pipe_stage.md
# id_pipe_stage

Parametrised, registered successor to the combinational decode stage. Sits between IF and EX: takes the fetched instruction, the controller's decoded control bits and the register-file read data. It resolves branches in ID and detects RAW hazards against a configurable in-flight history, inserting bubbles as needed. Results are held in an ID/EX pipeline register with a valid/ready handshake.

## Interface
Parameters:
- DATA_W, 32, operand/data width
- PC_W, 32, program-counter width
- EXE_W, 4, width of pass-through EXE command
- HIST_DEPTH, 3, number of issued destinations tracked for hazards (≥1)
- CNT_W, 16, stall-cycle counter width

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  instruction in ID is valid
- in_ready  out  1  ID accepts instruction this cycle
- instr  in  32  rs=[25:21], rt=[20:16], rd=[15:11], imm=[15:0]
- pc_in  in  PC_W  PC of instruction in ID
- rdata1, rdata2  in  DATA_W  register-file reads of rs, src2
- c_is_imm, c_st_or_bne, c_wb_en, c_mem_r, c_mem_w  in  1  controller outputs
- c_br  in  2  0 none, 1 BEQ, 2 BNE, 3 JMP
- c_exe  in  EXE_W  EXE command
- src2_addr  out  5  c_st_or_bne ? rd : rt (register-file read address)
- br_taken  out  1  combinational, taken branch accepted this cycle
- br_target  out  PC_W  pc_in + 1 + sext(imm), modulo 2^PC_W
- out_valid  out  1  ID/EX register holds an instruction
- out_ready  in  1  EX accepts
- out_val1, out_val2, out_st_val  out  DATA_W  rdata1; imm-or-rdata2; rdata2
- out_src1, out_src2_fw, out_dest  out  5  forwarding/destination addresses
- out_exe  out  EXE_W; out_wb_en, out_mem_r, out_mem_w  out  1
- stall_cycles  out  CNT_W  saturating count of hazard-stall cycles

## Operation
- Destination: c_is_imm ? rt : rd. An entry is "writing" only if c_wb_en=1 and dest≠0.
- Sign extension: imm[15] replicated to DATA_W. out_val2 = c_is_imm ? sext(imm) : rdata2. out_src2_fw = c_is_imm ? 0 : rt.
- History: HIST_DEPTH entries {valid, dest, is_load}. Entry 0 mirrors the ID/EX register. Shifts when adv = !out_valid || out_ready. The new entry 0 is the accepted instruction, or invalid on a bubble.
- Sources checked: rs always; src2_addr when !c_is_imm or c_st_or_bne. Register 0 never matches.
- Hazard, general rule: a source matches a valid entry as defined below.
- Branch operands are never forwarded. If c_br∈{1,2}, a match against any valid history entry is a hazard in both configurations.
- in_ready = adv && !hazard.
- Accept (in_valid && in_ready): ID/EX loads all outputs and out_valid=1.
- Hazard with adv=1: a bubble is inserted, out_valid=0, history shifts in invalid. stall_cycles increments, saturating at 2^CNT_W−1.
- adv=0: ID/EX and history hold; stall_cycles does not count.
- Branch: cond BEQ rdata1==rdata2, BNE !=, JMP always. br_taken = accept && cond. The branch itself still enters ID/EX with its control bits.
- Reset mid-operation clears everything immediately, regardless of pending handshakes.

## Timing
- Reset values: out_valid=0, all out_* data/control=0, history invalid, stall_cycles=0. in_ready, br_taken and br_target are combinational.
- Latency: 1 cycle from accept to out_valid.
- Throughput: 1/cycle when there are no hazards and out_ready=1.
- out_* are stable while out_valid && !out_ready.
- Simultaneous accept and downstream consume: new data replaces old in the same edge.

## Configuration
- IDPIPE_FWD_EN defined: a hazard requires a match with entry 0 whose is_load=1 (load-use). This gives one bubble. Other matches are left to EX forwarding.
- IDPIPE_FWD_EN undefined: any match with any valid entry of HIST_DEPTH is a hazard. Stalls last until the writer shifts out of the history.
- Branch-operand rule is identical in both configurations.

## Test plan
- Reset mid-stream: assert rst while out_valid=1 -> out_valid=0, stall_cycles=0, and in_ready=1 on the next cycle.
- Load-use (FWD_EN): load r5, then add r6=r5+r1 -> one bubble, add issued on cycle 3, stall_cycles=1. Without FWD_EN at HIST_DEPTH=3 -> 3 bubbles.
- ALU-ALU (FWD_EN): add r5, then sub using r5 -> no bubble, out_src1=5 on cycle 2.
- BEQ taken: rdata1=rdata2=7, pc_in=0x10, imm=0xFFFE -> br_taken=1, br_target=0x0F.
- Branch hazard: add r3, then BNE r3 -> stall until r3 leaves history, then branch evaluates.
- Back-pressure: out_ready=0 for 4 cycles -> outputs frozen, in_ready=0, stall_cycles unchanged, history unchanged.
- r0 dest: add r0, then use r0 -> no stall.
